// File: rtl/instruction_fetch_unit.sv
// Instruction fetch initiator: holds the PC, issues one read per cycle into a
// one-cycle-latency memory, and buffers returned words in a skid FIFO for decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          misalign_q, misalign_d;

  logic [31:0]   instr_mem_q [FIFO_DEPTH];
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [31:0]   occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (32'(p) == FIFO_DEPTH - 1) return '0;
    else                          return p + PW'(1);
  endfunction

  assign imem_addr    = pc_q;
  assign if_valid     = (count_q != '0);
  assign if_instr     = instr_mem_q[rd_ptr_q];
  assign if_pc        = pc_mem_q[rd_ptr_q];
  assign misalign_err = misalign_q;

  assign pop  = if_valid & if_ready;
  assign push = inflight_q & ~redirect_valid;

  // Entries already owed to the FIFO (stored + in flight) after this cycle's pop;
  // a new fetch is only issued if it is guaranteed a slot on return.
  assign occupancy = 32'(count_q) + 32'(inflight_q) - 32'(pop);
  assign issue     = ~redirect_valid & (occupancy < FIFO_DEPTH);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    misalign_d    = 1'b0;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      misalign_d = |redirect_pc[1:0];
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      misalign_q    <= misalign_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_instr;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule
